// File: rtl/booth_operand_recoder_if.sv
// Operand and issue signals between a sparse-PE operand source and the Booth recoder.
// The master modport drives operands and pe_ready; the slave modport is the recoder.
interface booth_operand_recoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       pe_ready;
    logic [7:0] en_multiplicand;
    logic [3:0] sign_en_multiplicand;
    logic       encode_valid;
    logic [2:0] nz_count;
    logic       skip_valid;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        output pe_ready,
        input  in_ready,
        input  en_multiplicand,
        input  sign_en_multiplicand,
        input  encode_valid,
        input  nz_count,
        input  skip_valid,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  pe_ready,
        output in_ready,
        output en_multiplicand,
        output sign_en_multiplicand,
        output encode_valid,
        output nz_count,
        output skip_valid,
        output busy
    );
endinterface

// File: rtl/booth_operand_recoder.sv
// Operand FIFO plus radix-4 Booth recoder that issues one operand per nonzero-digit slot.
// Define ZERO_SKIP_EN to retire all-zero operands with a skip_valid strobe instead of an issue.
module booth_operand_recoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    booth_operand_recoder_if.slave       bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (DATA_W != 8) begin : g_bad_width
        $error("booth_operand_recoder: DATA_W must be 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("booth_operand_recoder: DEPTH must be a power of 2, at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic [2:0]        slot_q;
    logic [7:0]        en_q;
    logic [3:0]        sign_q;
    logic [2:0]        nz_q;
    logic              enc_valid_q;

    logic       empty, full, push, issue, enc_issue, skip_issue;
    logic [7:0] head;
    logic [8:0] head_ext;
    logic [2:0] trip;
    logic [1:0] mag;
    logic       neg;
    logic [7:0] rec_en;
    logic [3:0] rec_sign;
    logic [2:0] rec_nz;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = bus.in_valid && !full;
    assign issue = !empty && (slot_q == 3'd0) && bus.pe_ready;
    assign head  = mem[rptr_q[AW-1:0]];

    // head_ext[0] stands in for x[-1] = 0, so digit i sees bits {x[2i+1], x[2i], x[2i-1]}.
    assign head_ext = {head, 1'b0};

    always_comb begin
        rec_en   = '0;
        rec_sign = '0;
        rec_nz   = '0;
        trip     = '0;
        mag      = '0;
        neg      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trip = head_ext[2*i+2 -: 3];
            case (trip)
                3'b001, 3'b010: begin mag = 2'b01; neg = 1'b0; end
                3'b011:         begin mag = 2'b10; neg = 1'b0; end
                3'b100:         begin mag = 2'b10; neg = 1'b1; end
                3'b101, 3'b110: begin mag = 2'b01; neg = 1'b1; end
                default:        begin mag = 2'b00; neg = 1'b0; end
            endcase
            rec_en[2*i +: 2] = mag;
            rec_sign[i]      = neg;
            rec_nz           = rec_nz + {2'b00, |mag};
        end
    end

`ifdef ZERO_SKIP_EN
    assign enc_issue  = issue && (rec_nz != 3'd0);
    assign skip_issue = issue && (rec_nz == 3'd0);
`else
    assign enc_issue  = issue;
    assign skip_issue = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            slot_q      <= '0;
            en_q        <= '0;
            sign_q      <= '0;
            nz_q        <= '0;
            enc_valid_q <= 1'b0;
        end else if (flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            slot_q      <= '0;
            en_q        <= '0;
            sign_q      <= '0;
            nz_q        <= '0;
            enc_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (issue) begin
                rptr_q <= rptr_q + 1'b1;
            end
            enc_valid_q <= enc_issue;
            if (enc_issue) begin
                en_q   <= rec_en;
                sign_q <= rec_sign;
                nz_q   <= rec_nz;
                // Slot lasts max(nz,1) cycles; a zero operand still takes one.
                slot_q <= (rec_nz == 3'd0) ? 3'd0 : rec_nz - 3'd1;
            end else if (slot_q != 3'd0) begin
                slot_q <= slot_q - 3'd1;
            end
        end
    end

`ifdef ZERO_SKIP_EN
    logic skip_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_q <= 1'b0;
        end else if (flush) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_issue;
        end
    end

    assign bus.skip_valid = skip_q;
`else
    assign bus.skip_valid = skip_issue;
`endif

    assign bus.in_ready             = !full;
    assign bus.en_multiplicand      = en_q;
    assign bus.sign_en_multiplicand = sign_q;
    assign bus.nz_count             = nz_q;
    assign bus.encode_valid         = enc_valid_q;
    assign bus.busy                 = !empty || (slot_q != 3'd0);
endmodule

// File: doc/booth_operand_recoder.md
Name: booth_operand_recoder

Overview:
- Upstream neighbour of the sparse Booth encoder in each sparse PE.
- Buffers signed 8-bit multiplicand operands in a small FIFO and recodes each one into four radix-4 Booth digits: a 2-bit magnitude code per digit plus a sign bit per digit.
- Issues one operand per encode slot. The slot length equals the number of nonzero digits, so the downstream encoder has finished walking the previous operand before the next encode_valid pulse.

Parameters:
- DEPTH, 4, operand FIFO depth; power of 2, minimum 2.
- DATA_W, 8, operand width; fixed at 8 (4 digits). Any other value is a configuration error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous clear of FIFO, slot counter and outputs
- in_valid  in  1  operand offered
- in_ready  out  1  FIFO not full
- in_data  in  8  signed two's-complement multiplicand
- pe_ready  in  1  downstream allows a new issue
- en_multiplicand  out  8  digit i magnitude code in [2i+1:2i]: 00 = zero, 01 = |1|, 10 = |2|
- sign_en_multiplicand  out  4  bit i = 1 when digit i is negative (only when nonzero)
- encode_valid  out  1  one-cycle issue strobe
- nz_count  out  3  nonzero-digit count of the issued operand (0..4)
- skip_valid  out  1  one-cycle strobe: zero operand retired without issue
- busy  out  1  FIFO nonempty or slot counter nonzero

Behaviour:
- Recode:
  - d_i = -2*x[2i+1] + x[2i] + x[2i-1], with x[-1] = 0.
  - |d_i| = 1 -> 01; |d_i| = 2 -> 10; 0 -> 00 with sign 0.
  - sign_i = 1 when d_i < 0.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = ~full, combinational from state only.
  - A full FIFO does not accept a push, even in a cycle with a simultaneous pop.
  - Pointers wrap modulo DEPTH, with an extra wrap bit for the full/empty distinction.
- Slot counter slot_cnt, 3 bits:
  - Issue condition: FIFO nonempty & slot_cnt == 0 & pe_ready.
  - On issue: pop the FIFO head. Next cycle, register en_multiplicand, sign_en_multiplicand and nz_count, and pulse encode_valid for exactly 1 cycle. Latency from push into an empty, idle FIFO to encode_valid is 2 cycles.
  - On issue, load slot_cnt = max(nz,1) - 1. Otherwise decrement while nonzero.
  - Issue-to-issue spacing is therefore max(nz,1) cycles; back-to-back issue is possible when nz ≤ 1.
  - slot_cnt keeps decrementing while pe_ready = 0; pe_ready only gates a new issue.
- Output stability:
  - en_multiplicand, sign_en_multiplicand and nz_count hold their last issued value between strobes.
  - They change only in the cycle encode_valid = 1.
- Reset (rst) and flush:
  - All outputs and internal state go to 0: encode_valid = 0, skip_valid = 0, codes = 0, nz_count = 0, slot_cnt = 0, FIFO empty.
  - in_ready = 1 after reset/flush is released.
  - Reset mid-slot drops the in-flight operand silently.
  - flush has priority over a push and over an issue in the same cycle.
- busy is combinational from state.

Optional Feature:
- ZERO_SKIP_EN:
  - Defined: an operand with nz = 0 (in_data = 0x00) is popped under the same issue condition, but raises skip_valid for 1 cycle instead of encode_valid. Output codes are unchanged and slot_cnt stays 0, so the next operand may issue in the following cycle.
  - Undefined: skip_valid is tied 0. A zero operand issues normally with en = 0x00, nz_count = 0 and a 1-cycle slot.

Test Plan:
- Recode, reset then single push:
  - 0x7F -> 2 cycles later encode_valid = 1, en = 8'b10000001, sign = 4'b0001, nz_count = 2.
  - 0x80 -> en = 8'b10000000, sign = 4'b1000, nz_count = 1.
- Slot spacing: push 0x55, 0xAA, 0x01 back-to-back with pe_ready = 1:
  - 0x55 -> en = 8'b01010101, sign = 0000, nz = 4.
  - 0xAA -> en = 8'b01010110, sign = 1111, nz = 4.
  - 0x01 -> en = 8'b00000001, nz = 1.
  - Strobes are 4 cycles apart, then 4 cycles apart.
- Full FIFO: push 5 operands of 0x55 with pe_ready = 0 -> in_ready = 0 after the 4th. The 5th is held off until the first issue after pe_ready rises. No operand is lost or duplicated.
- pe_ready gating: pe_ready = 0 for 10 cycles with the FIFO nonempty -> no encode_valid, busy = 1. Raising pe_ready -> strobe 1 cycle later.
- Zero operand: push 0x00 then 0x01:
  - ZERO_SKIP_EN defined -> skip_valid pulse, then encode_valid for 0x01 on the next cycle.
  - Undefined -> encode_valid with en = 0, nz_count = 0, followed 1 cycle later by 0x01.
- Mid-operation reset/flush: assert rst (and separately flush) 2 cycles into a 4-cycle slot with 2 operands queued -> all outputs 0, in_ready = 1, busy = 0. A following push of 0x01 issues 2 cycles later.
